// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, then shifts a byte
// with odd parity out on device-generated clocks and reports ACK/NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 1718,
    parameter int TIMEOUT_CYC = 214772,
    parameter int FILTER      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int TO_W  = 18;
    localparam int INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int FLT_W = $clog2(FILTER + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        WAIT_IDLE,
        DONE
    } state_t;

    // Line index 0 = clock, 1 = data.
    logic [1:0] raw_lvl;
    logic [1:0] filt_lvl;

    assign raw_lvl = {ps2_data_in, ps2_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic [1:0]       sync_reg;
            logic [FLT_W-1:0] cnt_reg;
            logic             filt_reg;

            // Level only flips after FILTER consecutive samples disagree with it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_reg <= 2'b11;
                    cnt_reg  <= '0;
                    filt_reg <= 1'b1;
                end else begin
                    sync_reg <= {sync_reg[0], raw_lvl[gi]};
                    if (sync_reg[1] == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == FLT_W'(FILTER - 1)) begin
                        filt_reg <= sync_reg[1];
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign filt_lvl[gi] = filt_reg;
        end
    endgenerate

    logic filt_clk;
    logic filt_data;
    logic clk_prev_reg;
    logic clk_fall;

    assign filt_clk  = filt_lvl[0];
    assign filt_data = filt_lvl[1];
    assign clk_fall  = clk_prev_reg & ~filt_clk;

    state_t           state_reg;
    logic [7:0]       data_reg;
    logic             parity_reg;
    logic             err_reg;
    logic [3:0]       bit_cnt_reg;
    logic [INH_W-1:0] inh_cnt_reg;
    logic [TO_W-1:0]  to_cnt_reg;
    logic             clk_oe_reg;
    logic             data_oe_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_out_reg;
    logic             timeout_hit;

    assign timeout_hit = (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            data_reg     <= '0;
            parity_reg   <= 1'b0;
            err_reg      <= 1'b0;
            bit_cnt_reg  <= '0;
            inh_cnt_reg  <= '0;
            to_cnt_reg   <= '0;
            clk_oe_reg   <= 1'b0;
            data_oe_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_out_reg  <= 1'b0;
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= filt_clk;
            done_reg     <= 1'b0;
            err_out_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (tx_req) begin
                        data_reg    <= tx_data;
                        parity_reg  <= ~^tx_data;
                        err_reg     <= 1'b0;
                        bit_cnt_reg <= '0;
                        inh_cnt_reg <= '0;
                        to_cnt_reg  <= '0;
                        clk_oe_reg  <= 1'b1;
                        data_oe_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= INHIBIT;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    // Timeout wins over every per-state action, including the inhibit count.
                    if (timeout_hit) begin
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b0;
                        err_reg     <= 1'b1;
                        done_reg    <= 1'b1;
                        err_out_reg <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                        case (state_reg)
                            INHIBIT: begin
                                inh_cnt_reg <= inh_cnt_reg + 1'b1;
                                if (inh_cnt_reg == INH_W'(INHIBIT_CYC - 2)) begin
                                    data_oe_reg <= 1'b1;
                                end
                                if (inh_cnt_reg == INH_W'(INHIBIT_CYC - 1)) begin
                                    clk_oe_reg  <= 1'b0;
                                    data_oe_reg <= 1'b1;
                                    bit_cnt_reg <= '0;
                                    state_reg   <= SEND;
                                end
                            end
                            SEND: begin
                                // bit_cnt_reg holds the number of falling edges seen so far.
                                if (clk_fall) begin
                                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                                    if (bit_cnt_reg < 4'd8) begin
                                        data_oe_reg <= ~data_reg[bit_cnt_reg[2:0]];
                                    end else if (bit_cnt_reg == 4'd8) begin
                                        data_oe_reg <= ~parity_reg;
                                    end else if (bit_cnt_reg == 4'd9) begin
                                        data_oe_reg <= 1'b0;
                                    end else begin
                                        err_reg   <= filt_data;
                                        state_reg <= WAIT_IDLE;
                                    end
                                end
                            end
                            WAIT_IDLE: begin
                                clk_oe_reg  <= 1'b0;
                                data_oe_reg <= 1'b0;
                                if (filt_clk && filt_data) begin
                                    done_reg    <= 1'b1;
                                    err_out_reg <= err_reg;
                                    state_reg   <= DONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign tx_busy     = busy_reg;
    assign tx_done     = done_reg;
    assign tx_err      = err_out_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a clocking PS/2 device model;
// expected completions are queued by the stimulus and checked by a monitor.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TO  = 3000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic [9:0] dev_frame = '0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYC(INH),
        .TIMEOUT_CYC(TO),
        .FILTER     (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic       chk_frame;
        logic [9:0] frame;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    logic chk_busy_fall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic err, input logic chk, input logic [9:0] frame);
        exp_t e;
        e.err       = err;
        e.chk_frame = chk;
        e.frame     = frame;
        sb_q.push_back(e);
        exp_done++;
    endtask

    // Monitor: every tx_done pops one expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (chk_busy_fall) begin
                check("busy_fall_after_done", 32'(tx_busy), 32'd0);
                chk_busy_fall = 1'b0;
            end
            if (tx_done) begin
                exp_t e;
                done_cnt++;
                $display("done #%0d err=%0b frame=%h busy=%0b", done_cnt, tx_err, dev_frame, tx_busy);
                if (sb_q.size() == 0) begin
                    check("unexpected_done_pulse", 32'(tx_done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("tx_err", 32'(tx_err), 32'(e.err));
                    check("busy_at_done", 32'(tx_busy), 32'd1);
                    if (e.chk_frame) check("device_frame", 32'(dev_frame), 32'(e.frame));
                end
                chk_busy_fall = 1'b1;
            end
        end
    end

    // Request a transfer and measure latency and the inhibit window.
    task automatic issue(input logic [7:0] d);
        int   hi;
        logic last_doe;
        @(negedge clk);
        tx_data = d;
        tx_req  = 1'b1;
        @(negedge clk);
        tx_req  = 1'b0;
        tx_data = ~d;
        check("latency_clk_oe", 32'(ps2_clk_oe), 32'd1);
        check("busy_after_req", 32'(tx_busy), 32'd1);
        hi = 0;
        last_doe = 1'b0;
        while (ps2_clk_oe && hi < 10 * INH) begin
            hi++;
            last_doe = ps2_data_oe;
            @(negedge clk);
        end
        check("inhibit_len", 32'(hi), 32'(INH));
        check("inhibit_final_data_oe", 32'(last_doe), 32'd1);
    endtask

    // Device: waits for start condition, generates nclk clocks, samples on rising edges.
    task automatic dev_xfer(input int nclk, input bit ack, input bit glitch);
        int t = 0;
        dev_frame = '0;
        while (!(ps2_clk_in && !ps2_data_in) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("device_saw_start", 32'(t < 2000), 32'd1);
        repeat (H) @(negedge clk);
        for (int i = 1; i <= nclk; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            if (i <= 10) dev_frame[i-1] = ps2_data_in;
            dev_clk_low = 1'b0;
            if (i == 10 && ack) dev_data_low = 1'b1;
            if (i == 11) dev_data_low = 1'b0;
            if (glitch && i == 3) begin
                repeat (5) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (2) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (H - 7) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt < exp_done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("done_within_budget", 32'(done_cnt >= exp_done), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    logic [7:0] vd[3];
    logic [9:0] vf[3];

    initial begin
        int k;
        vd[0] = 8'hED; vf[0] = 10'h3ED;
        vd[1] = 8'h07; vf[1] = 10'h207;
        vd[2] = 8'hFF; vf[2] = 10'h3FF;

        repeat (5) @(negedge clk);
        check("reset_outputs", 32'({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err}), 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Normal ACKed transfers
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 1'b1, vf[i]);
            issue(vd[i]);
            dev_xfer(11, 1'b1, 1'b0);
            wait_done();
        end

        // Absent device: release exactly TO cycles after acceptance
        push_exp(1'b1, 1'b0, 10'h000);
        issue(8'h3C);
        k = INH;
        while ((ps2_clk_oe || ps2_data_oe) && k < TO + 100) begin
            @(negedge clk);
            k++;
        end
        check("timeout_release_cycle", 32'(k), 32'(TO));
        wait_done();

        // Next request after a timeout
        push_exp(1'b0, 1'b1, 10'h300);
        issue(8'h00);
        dev_xfer(11, 1'b1, 1'b0);
        wait_done();

        // NACK
        push_exp(1'b1, 1'b1, 10'h355);
        issue(8'h55);
        dev_xfer(11, 1'b0, 1'b0);
        wait_done();

        // Short clock glitch plus a request while busy
        push_exp(1'b0, 1'b1, 10'h312);
        issue(8'h12);
        fork
            dev_xfer(11, 1'b1, 1'b1);
            begin
                repeat (60) @(negedge clk);
                tx_data = 8'h99;
                tx_req  = 1'b1;
                @(negedge clk);
                tx_req  = 1'b0;
            end
        join
        wait_done();

        // Reset in the middle of the data bits
        issue(8'hA5);
        dev_xfer(5, 1'b0, 1'b0);
        check("bit5_data_oe", 32'(ps2_data_oe), 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset_release", 32'({ps2_clk_oe, ps2_data_oe, tx_busy}), 32'd0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        check("no_done_on_reset", 32'(done_cnt), 32'(exp_done));

        push_exp(1'b0, 1'b1, 10'h3F3);
        issue(8'hF3);
        dev_xfer(11, 1'b1, 1'b0);
        wait_done();

        repeat (50) @(negedge clk);
        check("done_count", 32'(done_cnt), 32'd8);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
